// File: rtl/alu_exec_unit_if.sv
// Bus bundle for the execute stage. Signal names match the original flat
// port list, so existing connections map one-to-one.
//   master : drives the operands and control (decode/control side)
//   slave  : the execute unit; returns the ALU results, adder outputs and flags
//   Inputs to the unit : aluop[1:0], funct[5:0], a, b, pc, br_off, flag_we
//   Outputs of the unit: gout[2:0], result, zero, neg, ovf, pc_plus4, br_target,
//                        z_q, n_q, v_q
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] br_off;
    logic             flag_we;
    logic [2:0]       gout;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_target;
    logic             z_q;
    logic             n_q;
    logic             v_q;

    modport master (
        output aluop, funct, a, b, pc, br_off, flag_we,
        input  gout, result, zero, neg, ovf, pc_plus4, br_target, z_q, n_q, v_q
    );

    modport slave (
        input  aluop, funct, a, b, pc, br_off, flag_we,
        output gout, result, zero, neg, ovf, pc_plus4, br_target, z_q, n_q, v_q
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle MIPS-Extended datapath: ALU control
// decode, ALU, PC+4 adder, branch-target adder and registered Z/N/V flags.
// Ports:
//   clk   - rising-edge clock for the status flags
//   reset - synchronous, active-high; clears the status flags only
//   bus   - alu_exec_unit_if.slave (operands/control in, results/flags out)
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_exec_unit_if.slave       bus
);
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_NOR = 3'b100,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    alu_op_e          op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] result_c;
    logic             ovf_c;
    logic [WIDTH-1:0] pc_plus4_c;
    logic [2:0]       flags_d;
    logic [2:0]       flags_q;

    // ALU control decode
    always_comb begin
        op = OP_ADD;
        case (bus.aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_OR;
            default: begin
                case (bus.funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    default:   op = OP_ADD;
                endcase
            end
        endcase
    end

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    // Signed overflow: operands agree (add) / disagree (sub) in sign and the
    // result's sign differs from a.
    assign ovf_add = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB]  != bus.a[MSB]);
    assign ovf_sub = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);

    always_comb begin
        result_c = '0;
        ovf_c    = 1'b0;
        case (op)
            OP_AND: result_c = bus.a & bus.b;
            OP_OR:  result_c = bus.a | bus.b;
            OP_NOR: result_c = ~(bus.a | bus.b);
            OP_ADD: begin
                result_c = sum;
                ovf_c    = ovf_add;
            end
            OP_SUB: begin
                result_c = diff;
                ovf_c    = ovf_sub;
            end
            // Overflow-corrected sign of a-b gives a true signed less-than.
            OP_SLT: result_c = {{MSB{1'b0}}, diff[MSB] ^ ovf_sub};
            default: result_c = '0;
        endcase
    end

    assign pc_plus4_c = bus.pc + WIDTH'(4);

    assign bus.gout      = op;
    assign bus.result    = result_c;
    assign bus.zero      = (result_c == '0);
    assign bus.neg       = result_c[MSB];
    assign bus.ovf       = ovf_c;
    assign bus.pc_plus4  = pc_plus4_c;
    assign bus.br_target = pc_plus4_c + bus.br_off;

    // Status flags {z, n, v}
    assign flags_d = bus.flag_we ? {bus.zero, bus.neg, bus.ovf} : flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.z_q = flags_q[2];
    assign bus.n_q = flags_q[1];
    assign bus.v_q = flags_q[0];
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Reference flag state
    logic mz, mn, mv;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural reference: decode by instruction meaning, arithmetic in
    // 64-bit signed integers, slt as a true signed comparison.
    function automatic void ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [31:0] x, input logic [31:0] y,
                                    output logic [2:0] g, output logic [31:0] r,
                                    output logic v);
        int     kind;
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        kind = 0; // 0 add 1 sub 2 and 3 or 4 nor 5 slt
        case (op)
            2'b00: kind = 0;
            2'b01: kind = 1;
            2'b11: kind = 3;
            default: begin
                if      (fn == 6'h20) kind = 0;
                else if (fn == 6'h22) kind = 1;
                else if (fn == 6'h24) kind = 2;
                else if (fn == 6'h25) kind = 3;
                else if (fn == 6'h27) kind = 4;
                else if (fn == 6'h2A) kind = 5;
                else                  kind = 0;
            end
        endcase
        v = 1'b0;
        r = 32'h0;
        g = 3'b010;
        case (kind)
            0: begin g = 3'b010; s = sx + sy; r = s[31:0]; v = (longint'($signed(r)) != s); end
            1: begin g = 3'b110; s = sx - sy; r = s[31:0]; v = (longint'($signed(r)) != s); end
            2: begin g = 3'b000; r = x & y; end
            3: begin g = 3'b001; r = x | y; end
            4: begin g = 3'b100; r = ~(x | y); end
            default: begin g = 3'b111; r = (sx < sy) ? 32'd1 : 32'd0; end
        endcase
    endfunction

    // Apply inputs on the falling edge, away from the flag clock edge.
    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic we);
        @(negedge clk);
        bus.aluop   = op;
        bus.funct   = fn;
        bus.a       = x;
        bus.b       = y;
        bus.flag_we = we;
        #1;
    endtask

    // Advance one rising edge, updating the reference flags alongside.
    task automatic tick();
        logic [2:0]  g;
        logic [31:0] r;
        logic        v;
        ref_alu(bus.aluop, bus.funct, bus.a, bus.b, g, r, v);
        @(posedge clk);
        if (reset) begin
            mz = 1'b0; mn = 1'b0; mv = 1'b0;
        end else if (bus.flag_we) begin
            mz = (r == 32'h0); mn = r[31]; mv = v;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pc = 32'h0; bus.br_off = 32'h0;
        drive(2'b00, 6'h00, 32'd5, 32'd3, 1'b0);
        tick();
        tick();
        total++; if (bus.z_q !== 1'b0) begin bad++; $display("FAIL reset_z_q got=%b want=0", bus.z_q); end
        total++; if (bus.n_q !== 1'b0) begin bad++; $display("FAIL reset_n_q got=%b want=0", bus.n_q); end
        total++; if (bus.v_q !== 1'b0) begin bad++; $display("FAIL reset_v_q got=%b want=0", bus.v_q); end
        // Combinational path is independent of reset
        total++; if (bus.result !== 32'd8) begin bad++; $display("FAIL reset_comb_result got=%h want=00000008", bus.result); end
        reset = 1'b0;
    endtask

    task automatic test_add_overflow();
        drive(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1, 1'b1);
        total++; if (bus.gout !== 3'b010) begin bad++; $display("FAIL addov_gout got=%b want=010", bus.gout); end
        total++; if (bus.result !== 32'h80000000) begin bad++; $display("FAIL addov_result got=%h want=80000000", bus.result); end
        total++; if (bus.neg !== 1'b1) begin bad++; $display("FAIL addov_neg got=%b want=1", bus.neg); end
        total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL addov_ovf got=%b want=1", bus.ovf); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL addov_zero got=%b want=0", bus.zero); end
        tick();
        total++; if ({bus.z_q, bus.n_q, bus.v_q} !== 3'b011) begin bad++; $display("FAIL addov_flags got=%b want=011", {bus.z_q, bus.n_q, bus.v_q}); end
    endtask

    task automatic test_branch_compare();
        drive(2'b01, 6'h3F, 32'd5, 32'd5, 1'b1);
        total++; if (bus.gout !== 3'b110) begin bad++; $display("FAIL beq_gout got=%b want=110", bus.gout); end
        total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL beq_result got=%h want=00000000", bus.result); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL beq_zero got=%b want=1", bus.zero); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL beq_ovf got=%b want=0", bus.ovf); end
        tick();
        total++; if ({bus.z_q, bus.n_q, bus.v_q} !== 3'b100) begin bad++; $display("FAIL beq_flags got=%b want=100", {bus.z_q, bus.n_q, bus.v_q}); end
        // Hold when flag_we is low
        drive(2'b00, 6'h00, 32'hFFFFFFFF, 32'h0, 1'b0);
        tick();
        total++; if ({bus.z_q, bus.n_q, bus.v_q} !== 3'b100) begin bad++; $display("FAIL hold_flags got=%b want=100", {bus.z_q, bus.n_q, bus.v_q}); end
    endtask

    task automatic test_slt();
        drive(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 1'b0);
        total++; if (bus.gout !== 3'b111) begin bad++; $display("FAIL slt_gout got=%b want=111", bus.gout); end
        total++; if (bus.result !== 32'h1) begin bad++; $display("FAIL slt_neg1 got=%h want=00000001", bus.result); end
        drive(2'b10, 6'b101010, 32'h80000000, 32'h1, 1'b0);
        total++; if (bus.result !== 32'h1) begin bad++; $display("FAIL slt_ovfcorr got=%h want=00000001", bus.result); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL slt_ovf got=%b want=0", bus.ovf); end
        drive(2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 1'b0);
        total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL slt_maxmin got=%h want=00000000", bus.result); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL slt_zero got=%b want=1", bus.zero); end
    endtask

    task automatic test_logic_ops();
        drive(2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        total++; if (bus.result !== 32'hF000F000) begin bad++; $display("FAIL and_result got=%h want=F000F000", bus.result); end
        drive(2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        total++; if (bus.result !== 32'hFFF0FFF0) begin bad++; $display("FAIL or_result got=%h want=FFF0FFF0", bus.result); end
        drive(2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        total++; if (bus.result !== 32'h000F000F) begin bad++; $display("FAIL nor_result got=%h want=000F000F", bus.result); end
        total++; if (bus.gout !== 3'b100) begin bad++; $display("FAIL nor_gout got=%b want=100", bus.gout); end
        drive(2'b11, 6'h00, 32'h00000F00, 32'h0000000F, 1'b0);
        total++; if (bus.gout !== 3'b001 || bus.result !== 32'h00000F0F) begin bad++; $display("FAIL ori got=%b/%h want=001/00000F0F", bus.gout, bus.result); end
        drive(2'b10, 6'b111111, 32'h3, 32'h4, 1'b0);
        total++; if (bus.gout !== 3'b010 || bus.result !== 32'h7) begin bad++; $display("FAIL unk_funct got=%b/%h want=010/00000007", bus.gout, bus.result); end
    endtask

    task automatic test_adders();
        @(negedge clk);
        bus.pc = 32'hFFFFFFFC; bus.br_off = 32'hFFFFFFF8;
        #1;
        total++; if (bus.pc_plus4 !== 32'h0) begin bad++; $display("FAIL pc4_wrap got=%h want=00000000", bus.pc_plus4); end
        total++; if (bus.br_target !== 32'hFFFFFFF8) begin bad++; $display("FAIL brt_wrap got=%h want=FFFFFFF8", bus.br_target); end
        bus.pc = 32'h0; bus.br_off = 32'h10;
        #1;
        total++; if (bus.pc_plus4 !== 32'h4) begin bad++; $display("FAIL pc4 got=%h want=00000004", bus.pc_plus4); end
        total++; if (bus.br_target !== 32'h14) begin bad++; $display("FAIL brt got=%h want=00000014", bus.br_target); end
    endtask

    task automatic test_reset_dominates();
        drive(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1, 1'b1);
        tick();
        total++; if ({bus.z_q, bus.n_q, bus.v_q} !== 3'b011) begin bad++; $display("FAIL rstdom_pre got=%b want=011", {bus.z_q, bus.n_q, bus.v_q}); end
        reset = 1'b1;
        tick();
        total++; if ({bus.z_q, bus.n_q, bus.v_q} !== 3'b000) begin bad++; $display("FAIL rstdom_flags got=%b want=000", {bus.z_q, bus.n_q, bus.v_q}); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  g;
        logic [31:0] r, x, y, p, o;
        logic        v;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [5:0]  fset [6];
        fset = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fset[$urandom_range(0, 5)];
            case ($urandom_range(0, 3))
                0: begin x = $urandom; y = x; end
                1: begin x = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom)}; y = {x[31], 31'($urandom)}; end
                2: begin x = 32'($urandom_range(0, 3)) | 32'h80000000; y = 32'h7FFFFFFF - 32'($urandom_range(0, 3)); end
                default: begin x = $urandom; y = $urandom; end
            endcase
            p = $urandom; o = $urandom;
            reset = ($urandom_range(0, 15) == 0);
            drive(op, fn, x, y, 1'($urandom_range(0, 1)));
            bus.pc = p; bus.br_off = o;
            #1;
            ref_alu(op, fn, x, y, g, r, v);
            total++; if (bus.gout !== g) begin bad++; $display("FAIL rnd_gout i=%0d got=%b want=%b", i, bus.gout, g); end
            total++; if (bus.result !== r) begin bad++; $display("FAIL rnd_result i=%0d op=%b fn=%h a=%h b=%h got=%h want=%h", i, op, fn, x, y, bus.result, r); end
            total++; if (bus.zero !== (r == 32'h0)) begin bad++; $display("FAIL rnd_zero i=%0d got=%b", i, bus.zero); end
            total++; if (bus.neg !== r[31]) begin bad++; $display("FAIL rnd_neg i=%0d got=%b want=%b", i, bus.neg, r[31]); end
            total++; if (bus.ovf !== v) begin bad++; $display("FAIL rnd_ovf i=%0d a=%h b=%h got=%b want=%b", i, x, y, bus.ovf, v); end
            total++; if (bus.pc_plus4 !== p + 32'd4) begin bad++; $display("FAIL rnd_pc4 i=%0d got=%h", i, bus.pc_plus4); end
            total++; if (bus.br_target !== p + 32'd4 + o) begin bad++; $display("FAIL rnd_brt i=%0d got=%h", i, bus.br_target); end
            tick();
            total++; if ({bus.z_q, bus.n_q, bus.v_q} !== {mz, mn, mv}) begin bad++; $display("FAIL rnd_flags i=%0d got=%b want=%b", i, {bus.z_q, bus.n_q, bus.v_q}, {mz, mn, mv}); end
        end
        reset = 1'b0;
    endtask

    initial begin
        mz = 1'b0; mn = 1'b0; mv = 1'b0;
        reset = 1'b1;
        bus.aluop = 2'b00; bus.funct = 6'h00; bus.a = 32'h0; bus.b = 32'h0;
        bus.pc = 32'h0; bus.br_off = 32'h0; bus.flag_we = 1'b0;
        test_reset();
        test_add_overflow();
        test_branch_compare();
        test_slt();
        test_logic_ops();
        test_adders();
        test_reset_dominates();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
